// File: rtl/mem_model_apb_pkg.sv
// Shared types and sizing helpers for the APB word-memory completer.
// Imported by the bus interface users, the RAM and the top level.
package mem_model_apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WCNT_W = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_idx_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_model_apb_ws_if.sv
// APB4 requester/completer signal bundle with an extra dynamic wait-count field.
interface mem_model_apb_ws_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);
  logic                   psel;
  logic                   penable;
  logic [ADDRWIDTH-1:0]   paddr;
  logic                   pwrite;
  logic [DATAWIDTH-1:0]   pwdata;
  logic [DATAWIDTH/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [3:0]             pwait;
  logic [DATAWIDTH-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pwait,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pwait,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/mem_model_apb_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-enabled output that holds its value between reads.
module mem_model_apb_ram
  import mem_model_apb_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int DATAWIDTH = 32,
  localparam int LANES    = lane_count(DATAWIDTH),
  localparam int IDXW     = idx_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic [IDXW-1:0]      addr_i,
  input  logic                 re_i,
  input  logic [LANES-1:0]     we_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LANES; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_model_apb_ws.sv
// APB4 memory completer: setup/access FSM, wait-state counter, address and
// protection decode with PSLVERR, backed by mem_model_apb_ram.
module mem_model_apb_ws
  import mem_model_apb_pkg::*;
#(
  parameter int                   ADDRWIDTH   = 32,
  parameter int                   DATAWIDTH   = 32,
  parameter int                   DEPTH       = 1024,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR   = '0,
  parameter int                   WAIT_STATES = 0,
  parameter bit                   DYN_WAIT    = 1'b0,
  parameter bit                   SECURE      = 1'b0
) (
  input  logic               pclk,
  input  logic               preset,
  mem_model_apb_ws_if.slave  bus
);

  localparam int LANES  = lane_count(DATAWIDTH);
  localparam int LANEW  = lane_idx_width(DATAWIDTH);
  localparam int IDXW   = idx_width(DEPTH);
  localparam int SPAN_W = LANEW + IDXW;
  localparam logic [WCNT_W-1:0] WS = WCNT_W'(WAIT_STATES);

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic                 rd_zero_q;
  logic [IDXW-1:0]      idx_q;
  logic                 write_q;
  logic                 err_q;
  logic [DATAWIDTH-1:0] wdata_q;
  logic [LANES-1:0]     strb_q;

  logic                 in_range, misaligned, prot_err, setup_err;
  logic [IDXW-1:0]      setup_idx;
  logic [WCNT_W-1:0]    wload;
  logic                 setup, commit, pready, pslverr;
  logic [IDXW-1:0]      ram_addr;
  logic                 ram_re;
  logic [LANES-1:0]     ram_we;
  logic [DATAWIDTH-1:0] ram_rdata;
  logic                 unused_pprot;

  // BASE_ADDR is aligned to the window size, so the window test is a
  // compare of the bits above it and the word index is a plain slice.
  assign in_range     = (bus.paddr >> SPAN_W) == (BASE_ADDR >> SPAN_W);
  assign misaligned   = |bus.paddr[LANEW-1:0];
  assign prot_err     = SECURE && bus.pprot[1];
  assign setup_err    = !in_range || misaligned || prot_err;
  assign setup_idx    = bus.paddr[SPAN_W-1:LANEW];
  assign wload        = DYN_WAIT ? bus.pwait : WS;
  assign unused_pprot = ^{bus.pprot[2], bus.pprot[0]};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    setup   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
          wcnt_d  = wload;
        end else if (bus.psel && bus.penable) begin
          // Access phase with no setup: flag it and do nothing else.
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.psel && bus.penable) begin
          if (wcnt_q == '0) begin
            pready  = 1'b1;
            pslverr = err_q;
            commit  = write_q && !err_q;
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q - WCNT_W'(1);
          end
        end else begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      rd_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (setup && !bus.pwrite) rd_zero_q <= setup_err;
    end
  end

  always_ff @(posedge pclk) begin
    if (setup) begin
      idx_q   <= setup_idx;
      write_q <= bus.pwrite;
      err_q   <= setup_err;
      wdata_q <= bus.pwdata;
      strb_q  <= bus.pstrb;
    end
  end

  // Reads use the setup-cycle address so data is ready in the first access cycle.
  assign ram_re   = setup && !bus.pwrite && !setup_err && !preset;
  assign ram_we   = (commit && !preset) ? strb_q : '0;
  assign ram_addr = commit ? idx_q : setup_idx;

  mem_model_apb_ram #(
    .DEPTH     (DEPTH),
    .DATAWIDTH (DATAWIDTH)
  ) u_ram (
    .clk_i   (pclk),
    .addr_i  (ram_addr),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.prdata  = rd_zero_q ? '0 : ram_rdata;
  assign bus.pready  = pready;
  assign bus.pslverr = pslverr;

endmodule

// File: tb/tb_mem_model_apb_ws.sv
// Scoreboard bench for mem_model_apb_ws: two instances (static 3-wait secure,
// dynamic-wait non-secure) sharing one APB driver selected by 'sel'.
module tb_mem_model_apb_ws;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        sel = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0, pwait = '0;
  logic [2:0]  pprot = '0;

  always #5 pclk = ~pclk;

  mem_model_apb_ws_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus_s ();
  mem_model_apb_ws_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus_d ();

  assign bus_s.psel    = psel & ~sel;
  assign bus_d.psel    = psel & sel;
  assign bus_s.penable = penable;  assign bus_d.penable = penable;
  assign bus_s.paddr   = paddr;    assign bus_d.paddr   = paddr;
  assign bus_s.pwrite  = pwrite;   assign bus_d.pwrite  = pwrite;
  assign bus_s.pwdata  = pwdata;   assign bus_d.pwdata  = pwdata;
  assign bus_s.pstrb   = pstrb;    assign bus_d.pstrb   = pstrb;
  assign bus_s.pprot   = pprot;    assign bus_d.pprot   = pprot;
  assign bus_s.pwait   = pwait;    assign bus_d.pwait   = pwait;

  mem_model_apb_ws #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_STATES(3), .DYN_WAIT(1'b0), .SECURE(1'b1)
  ) dut_s (.pclk(pclk), .preset(preset), .bus(bus_s));

  mem_model_apb_ws #(
    .ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .WAIT_STATES(0), .DYN_WAIT(1'b1), .SECURE(1'b0)
  ) dut_d (.pclk(pclk), .preset(preset), .bus(bus_d));

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  assign pready_m  = sel ? bus_d.pready  : bus_s.pready;
  assign pslverr_m = sel ? bus_d.pslverr : bus_s.pslverr;
  assign prdata_m  = sel ? bus_d.prdata  : bus_s.prdata;

  typedef struct {
    string       name;
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   asserts = 0;
  int   fails = 0;
  int   wc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts access-phase wait cycles and scores each completion.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (!pready_m) begin
        wc++;
      end else begin
        if (q.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL unexpected_pready: got pready=1, expected no completion");
        end else begin
          mon_e = q.pop_front();
          check({mon_e.name, "_err"}, 32'(pslverr_m), 32'(mon_e.err));
          if (mon_e.chk) check({mon_e.name, "_data"}, prdata_m, mon_e.data);
          check({mon_e.name, "_waits"}, 32'(wc), 32'(mon_e.waits));
        end
        wc = 0;
      end
    end else begin
      wc = 0;
    end
  end

  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [3:0] pw, input logic [3:0] pw_mid,
                      input logic err, input logic [31:0] rdexp, input int waits);
    exp_t e;
    bit   done;
    e.name = name; e.err = err; e.chk = !wr; e.data = rdexp; e.waits = waits;
    q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    pstrb = strb; pprot = prot; pwait = pw;
    @(posedge pclk); #1;
    penable = 1'b1; pwait = pw_mid;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (pready_m) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      asserts++;
      fails++;
      $display("FAIL %s_timeout: got no pready in 40 cycles, expected completion", name);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] pw,
                    input logic err, input int waits);
    xfer(name, 1'b1, addr, data, strb, prot, pw, pw, err, 32'h0, waits);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [2:0] prot,
                    input logic [3:0] pw, input logic err, input logic [31:0] exp, input int waits);
    xfer(name, 1'b0, addr, 32'h0, 4'h0, prot, pw, pw, err, exp, waits);
  endtask

  task automatic idle_cycle();
    @(posedge pclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("rst_s_pready",  32'(bus_s.pready),  32'h0);
    check("rst_s_pslverr", 32'(bus_s.pslverr), 32'h0);
    check("rst_s_prdata",  bus_s.prdata,       32'h0);
    check("rst_d_pready",  32'(bus_d.pready),  32'h0);
    check("rst_d_pslverr", 32'(bus_d.pslverr), 32'h0);
    check("rst_d_prdata",  bus_d.prdata,       32'h0);
    idle_cycle();

    // Dynamic-wait, non-secure instance.
    sel = 1'b1;
    wr("wr_base",   BASE,          32'h0102_0304, 4'hF, 3'b000, 4'd0, 1'b0, 0);
    wr("wr_beef",   BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 4'd0, 1'b0, 0);
    rd("rd_beef",   BASE + 32'h10, 3'b000, 4'd0, 1'b0, 32'hDEAD_BEEF, 0);
    wr("wr_fill",   BASE + 32'h20, 32'h1122_3344, 4'hF, 3'b000, 4'd0, 1'b0, 0);
    wr("wr_strb5",  BASE + 32'h20, 32'hAABB_CCDD, 4'h5, 3'b000, 4'd0, 1'b0, 0);
    rd("rd_strb5",  BASE + 32'h20, 3'b000, 4'd0, 1'b0, 32'h11BB_33DD, 0);
    wr("wr_fill2",  BASE + 32'h24, 32'h5566_7788, 4'hF, 3'b000, 4'd0, 1'b0, 0);
    wr("wr_strb0",  BASE + 32'h24, 32'hFFFF_FFFF, 4'h0, 3'b000, 4'd0, 1'b0, 0);
    rd("rd_strb0",  BASE + 32'h24, 3'b000, 4'd0, 1'b0, 32'h5566_7788, 0);
    wr("wr_oor",    BASE + 32'h40, 32'h9999_9999, 4'hF, 3'b000, 4'd0, 1'b1, 0);
    rd("rd_alias0", BASE,          3'b000, 4'd0, 1'b0, 32'h0102_0304, 0);
    wr("wr_misal",  BASE + 32'h12, 32'h7777_7777, 4'hF, 3'b000, 4'd0, 1'b1, 0);
    rd("rd_after_misal", BASE + 32'h10, 3'b000, 4'd0, 1'b0, 32'hDEAD_BEEF, 0);
    rd("rd_oor",    BASE + 32'h40, 3'b000, 4'd0, 1'b1, 32'h0, 0);
    rd("rd_beef2",  BASE + 32'h10, 3'b000, 4'd0, 1'b0, 32'hDEAD_BEEF, 0);
    rd("rd_misal",  BASE + 32'h02, 3'b000, 4'd0, 1'b1, 32'h0, 0);
    xfer("rd_dyn5", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 3'b000, 4'd5, 4'd0,
         1'b0, 32'hDEAD_BEEF, 5);
    wr("wr_dyn2",   BASE + 32'h2C, 32'h0BAD_F00D, 4'hF, 3'b000, 4'd2, 1'b0, 2);
    rd("rd_dyn2",   BASE + 32'h2C, 3'b010, 4'd0, 1'b0, 32'h0BAD_F00D, 0);

    // Access phase without a setup cycle.
    begin
      exp_t e;
      e.name = "proto_viol"; e.err = 1'b1; e.chk = 1'b0; e.data = 32'h0; e.waits = 0;
      q.push_back(e);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE;
      pwdata = 32'hBAD0_BAD0; pstrb = 4'hF;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
    end
    rd("rd_after_proto", BASE, 3'b000, 4'd0, 1'b0, 32'h0102_0304, 0);

    // Reset in the middle of a waited write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE;
    pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pwait = 4'd5;
    @(posedge pclk); #1 penable = 1'b1; pwait = 4'd0;
    @(posedge pclk);
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("rst_abort_pready", 32'(bus_d.pready), 32'h0);
    check("rst_abort_prdata", bus_d.prdata, 32'h0);
    idle_cycle();
    rd("rd_after_rst", BASE, 3'b000, 4'd0, 1'b0, 32'h0102_0304, 0);

    // Static three-wait, secure instance.
    idle_cycle();
    sel = 1'b0;
    wr("s_wr",        BASE + 32'h08, 32'h1234_5678, 4'hF, 3'b000, 4'd0, 1'b0, 3);
    rd("s_rd",        BASE + 32'h08, 3'b000, 4'd9, 1'b0, 32'h1234_5678, 3);
    wr("s_wr_nonsec", BASE + 32'h08, 32'h9999_9999, 4'hF, 3'b010, 4'd0, 1'b1, 3);
    rd("s_rd_sec",    BASE + 32'h08, 3'b000, 4'd0, 1'b0, 32'h1234_5678, 3);
    rd("s_rd_nonsec", BASE + 32'h08, 3'b010, 4'd0, 1'b1, 32'h0, 3);
    rd("s_rd_prot5",  BASE + 32'h08, 3'b101, 4'd0, 1'b0, 32'h1234_5678, 3);

    repeat (3) idle_cycle();
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
